// File: rtl/outpass4_handshake_tx.sv
// Fabric-to-pad 4-bit transmit BEL: valid/ready handshake to external pins, either
// through a small first-word-fall-through FIFO or as a zero-latency combinational bypass.
module outpass4_handshake_tx #(
  parameter int DEPTH        = 4,
  parameter int NoConfigBits = 2
) (
  input  logic                      UserCLK,
  input  logic                      UserRSTn,
  input  logic [3:0]                I,
  input  logic                      I_valid,
  output logic                      I_ready,
  output logic [3:0]                O,
  output logic                      O_valid,
  input  logic                      O_ready,
  output logic [$clog2(DEPTH):0]    Level,
  input  logic [NoConfigBits-1:0]   ConfigBits
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] FullCount = LvlW'(DEPTH);

  logic            buffered;
  logic            holdLast;
  logic [3:0]      fifoMem [DEPTH];
  logic [PtrW-1:0] wrPtrReg;
  logic [PtrW-1:0] rdPtrReg;
  logic [LvlW-1:0] countReg;
  logic [LvlW-1:0] countNext;
  logic [3:0]      lastWordReg;
  logic            bufIReady;
  logic            bufOValid;
  logic            push;
  logic            pop;
  logic [3:0]      headWord;
  logic [3:0]      emptyWord;

  assign buffered = ConfigBits[0];
  assign holdLast = ConfigBits[1];

  // Ready depends only on registered occupancy so the fabric never sees a pad-to-fabric path.
  assign bufIReady = (countReg != FullCount);
  assign bufOValid = (countReg != '0);
  assign push      = buffered & I_valid & bufIReady;
  assign pop       = buffered & bufOValid & O_ready;
  assign headWord  = fifoMem[rdPtrReg];
  assign emptyWord = holdLast ? lastWordReg : 4'b0000;

  always_comb begin
    countNext = countReg;
    case ({push, pop})
      2'b10:   countNext = countReg + 1'b1;
      2'b01:   countNext = countReg - 1'b1;
      default: countNext = countReg;
    endcase
  end

  always_ff @(posedge UserCLK or negedge UserRSTn) begin
    if (!UserRSTn) begin
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      countReg    <= '0;
      lastWordReg <= 4'b0000;
    end else if (!buffered) begin
      wrPtrReg    <= '0;
      rdPtrReg    <= '0;
      countReg    <= '0;
      lastWordReg <= 4'b0000;
    end else begin
      if (push) wrPtrReg <= wrPtrReg + 1'b1;
      if (pop) begin
        rdPtrReg    <= rdPtrReg + 1'b1;
        lastWordReg <= headWord;
      end
      countReg <= countNext;
    end
  end

  // Storage is only observable through a nonzero count, so it needs no reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gEntry
      always_ff @(posedge UserCLK) begin
        if (push && (wrPtrReg == PtrW'(gi))) fifoMem[gi] <= I;
      end
    end
  endgenerate

  always_comb begin
    if (buffered) begin
      O       = bufOValid ? headWord : emptyWord;
      O_valid = bufOValid;
      I_ready = bufIReady;
      Level   = countReg;
    end else begin
      O       = I;
      O_valid = I_valid;
      I_ready = O_ready;
      Level   = '0;
    end
  end

endmodule

// File: doc/outpass4_handshake_tx.md
# outpass4_handshake_tx

Fabric-to-pad output BEL. It is the transmit-side counterpart of the 4-bit input-pass BELs. It carries a 4-bit word from the switch matrix to EXTERNAL top-level pins over a valid/ready handshake. In buffered mode a small first-word-fall-through FIFO absorbs external backpressure. A per-tile configuration bit selects between this buffered mode and a zero-latency combinational bypass.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- NoConfigBits, 2: configuration bits consumed.
  - ConfigBits[0]: 0 = bypass, 1 = buffered.
  - ConfigBits[1]: 0 = drive O to zero when empty, 1 = hold the last transmitted word when empty.

Ports (name, direction, width, meaning):
- UserCLK, input, 1: EXTERNAL, SHARED_PORT. The single clock; all state updates on its rising edge.
- UserRSTn, input, 1: EXTERNAL, SHARED_PORT. Reset, asynchronous, active-low.
- I, input, 4: word from the switch matrix.
- I_valid, input, 1: fabric offers I.
- I_ready, output, 1: block accepts I. Goes to the switch matrix.
- O, output, 4: EXTERNAL. Transmitted word.
- O_valid, output, 1: EXTERNAL. O holds a valid word.
- O_ready, input, 1: EXTERNAL. Far end accepts O.
- Level, output, log2(DEPTH)+1: current FIFO occupancy. Goes to the switch matrix.
- ConfigBits, input, NoConfigBits: GLOBAL; static during normal use.

## Operation
Bypass mode (ConfigBits[0]=0), purely combinational:
- O=I, O_valid=I_valid, I_ready=O_ready.
- FIFO state is cleared synchronously on every edge: pointers=0, count=0, last-word register=0.
- Level=0.

Buffered mode (ConfigBits[0]=1):
- State: write pointer, read pointer (each log2(DEPTH) bits, wrapping modulo DEPTH), count (0..DEPTH), last-word register (4 bits).
- push = I_valid & I_ready. I_ready = (count != DEPTH). I_ready is derived only from registered count, never from O_ready.
- pop = O_valid & O_ready. O_valid = (count != 0).
- On push, I is written at the write pointer and the write pointer increments.
- On pop, the read pointer increments and the last-word register is loaded with the popped word.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both, or neither: unchanged.
- O is the head entry when count>0. When count=0, O is the last-word register if ConfigBits[1]=1, otherwise 4'b0000.
- Level = count.

Boundary conditions:
- Full (count=DEPTH): I_ready=0, so no push. A pop that cycle makes I_ready high the following cycle.
- Empty (count=0): O_valid=0, so no pop. A push that cycle makes O_valid high the following cycle.
- Simultaneous push and pop at 0<count<DEPTH: both take effect and count is unchanged.
- Pointers wrap from DEPTH−1 to 0 with no gap.
- Mode 1→0 while words are buffered: they are discarded at the next edge. No partial-word output is produced.
- Mode 0→1: the block starts empty.
- Reset asserted mid-transfer: all state clears immediately, asynchronously. Any in-flight handshake is abandoned.

Reset values in buffered mode:
- O_valid=0, I_ready=1, Level=0, O=4'b0000.
- Last-word register = 0.

## Timing
- Buffered latency: a word pushed at edge k is on O with O_valid=1 from just after edge k. It is popped at the first edge k+n (n≥1) where O_ready=1.
- Throughput: one word per cycle sustained when O_ready is held high. No bubbles at wrap or at the full/empty transitions.
- Bypass latency: zero cycles, combinational.
- Handshake rules for the far end:
  - Once O_valid=1, O and O_valid stay stable until a pop occurs.
  - O_valid never drops without a pop, except on reset or a mode change.
- Reset release: the first push can occur at the first rising UserCLK edge after UserRSTn deasserts.

## Test plan
- Reset check: UserRSTn=0 with ConfigBits=2'b11 → O_valid=0, I_ready=1, Level=0, O=0. Release, push 4'hA at edge 1 with O_ready=0 → after edge 1: O=4'hA, O_valid=1, Level=1.
- Fill and backpressure: O_ready=0, DEPTH=4, push 1,2,3,4 → after 4 edges Level=4, I_ready=0. A 5th I_valid with value 5 is not accepted. Raise O_ready → O shows 1,2,3,4 on consecutive cycles.
- Streaming with wrap: O_ready=1, push 0..15 on consecutive cycles → O sequence is 0..15, each with a one-cycle latency. Level stays ≤1 and I_ready never drops.
- Simultaneous push and pop at Level=2: the cycle with push of 4'h7 and pop of the head gives Level=2 after the edge, and 4'h7 ends up at the tail.
- Empty-output policy: after draining a final 4'hC, ConfigBits[1]=1 → O=4'hC with O_valid=0; ConfigBits[1]=0 → O=4'h0.
- Mode switch and mid-stream reset:
  - Level=3, set ConfigBits[0]=0 → next edge Level=0, and O tracks I combinationally.
  - Return to buffered and load Level=2, then pulse UserRSTn low between edges → O_valid=0 and Level=0 immediately, without waiting for an edge.
